// File: rtl/cla_group_carry_pipe_if.sv
// Handshake bundle for the second-level CLA carry pipeline: group (G,P) pairs
// plus carry-in on the input side, group carries and the block (G,P) pair on the output side.
interface cla_group_carry_pipe_if #(
  parameter int NumGroups = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [2*NumGroups-1:0] qg_in;
  logic                   cin;
  logic                   out_valid;
  logic                   out_ready;
  logic [NumGroups-1:0]   c_grp;
  logic                   cout;
  logic [1:0]             blk_qg;

  modport master (
    output in_valid, qg_in, cin, out_ready,
    input  in_ready, out_valid, c_grp, cout, blk_qg
  );

  modport slave (
    input  in_valid, qg_in, cin, out_ready,
    output in_ready, out_valid, c_grp, cout, blk_qg
  );
endinterface

// File: rtl/cla_group_carry_pipe.sv
// Second-level carry lookahead: Kogge-Stone prefix over the group (G,P) pairs,
// split across two valid/ready register stages for full-throughput timing closure.
module cla_group_carry_pipe #(
  parameter int NumGroups = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  cla_group_carry_pipe_if.slave   bus
);
  localparam int L   = $clog2(NumGroups);
  localparam int LS1 = (L + 1) / 2;

  typedef logic [NumGroups-1:0] vec_t;

  typedef struct packed {
    vec_t g;
    vec_t p;
    logic cin;
  } s1_t;

  typedef struct packed {
    vec_t       c;
    logic       cout;
    logic [1:0] blk;
  } s2_t;

  // Prefix levels lo..hi-1, level n combining spans at distance 2**n.
  // Descending index keeps each level reading only the previous level's values.
  function automatic logic [2*NumGroups-1:0] prefix(input vec_t g_in, input vec_t p_in,
                                                     input int lo, input int hi);
    vec_t g;
    vec_t p;
    g = g_in;
    p = p_in;
    for (int lvl = lo; lvl < hi; lvl++) begin
      for (int i = NumGroups - 1; i >= (1 << lvl); i--) begin
        g[i] = g[i] | (p[i] & g[i - (1 << lvl)]);
        p[i] = p[i] & p[i - (1 << lvl)];
      end
    end
    return {g, p};
  endfunction

  logic [2:1] vld_pipe;
  s1_t        s1;
  s2_t        s2;
  s1_t        s1_nxt;
  s2_t        s2_nxt;
  vec_t       g_raw, p_raw;
  vec_t       g_fin, p_fin;
  logic       s1_adv, s2_adv;

  assign s2_adv = !vld_pipe[2] || bus.out_ready;
  assign s1_adv = !vld_pipe[1] || s2_adv;

  always_comb begin
    g_raw = '0;
    p_raw = '0;
    for (int k = 0; k < NumGroups; k++) begin
      g_raw[k] = bus.qg_in[2*k+1];
      p_raw[k] = bus.qg_in[2*k];
    end
  end

  always_comb begin
    s1_nxt     = '0;
    s1_nxt.cin = bus.cin;
    {s1_nxt.g, s1_nxt.p} = prefix(g_raw, p_raw, 0, LS1);
  end

  // After the last level g_fin[k]/p_fin[k] span groups k..0, so each carry is one AND-OR with cin.
  always_comb begin
    {g_fin, p_fin} = prefix(s1.g, s1.p, LS1, L);
    s2_nxt      = '0;
    s2_nxt.c[0] = s1.cin;
    for (int k = 0; k < NumGroups - 1; k++)
      s2_nxt.c[k+1] = g_fin[k] | (p_fin[k] & s1.cin);
    s2_nxt.cout = g_fin[NumGroups-1] | (p_fin[NumGroups-1] & s1.cin);
    s2_nxt.blk  = {g_fin[NumGroups-1], p_fin[NumGroups-1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
    end else begin
      if (s2_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) s2 <= s2_nxt;
      end
      if (s1_adv) begin
        vld_pipe[1] <= bus.in_valid;
        if (bus.in_valid) s1 <= s1_nxt;
      end
    end
  end

  assign bus.in_ready  = s1_adv && !rst;
  assign bus.out_valid = vld_pipe[2];
  assign bus.c_grp     = s2.c;
  assign bus.cout      = s2.cout;
  assign bus.blk_qg    = s2.blk;
endmodule

// File: doc/cla_group_carry_pipe.md
Name: cla_group_carry_pipe

Overview:
- Second-level carry-lookahead unit for wide CLA adders. It sits directly downstream of the per-group q-generation stage.
- Consumes the group (generate, propagate) pairs of NumGroups groups plus the adder carry-in.
- Produces the carry-in for every group, the adder carry-out and the block-level (generate, propagate) pair.
- Result moves through a 2-stage valid/ready pipeline, so wide adders close timing at full throughput.

Parameters:
- NumGroups, 4, number of groups combined; legal range 2..16.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  qg_in/cin valid this cycle
- in_ready  output  1  unit accepts input this cycle
- qg_in  input  2*NumGroups  group pairs; qg_in[2k+1]=G_k (generate), qg_in[2k]=P_k (propagate)
- cin  input  1  adder carry-in
- out_valid  output  1  outputs hold a valid result
- out_ready  input  1  downstream accepts result this cycle
- c_grp  output  NumGroups  carry into group k; c_grp[0]=cin of that transaction
- cout  output  1  carry out of group NumGroups-1
- blk_qg  output  2  {G_blk, P_blk} of the whole block

Behaviour:
- Function, per transaction:
  - c_grp[0]=cin.
  - c_grp[k+1]=G_k | (P_k & c_grp[k]) for k=0..NumGroups-2.
  - cout=G_{N-1} | (P_{N-1} & c_grp[N-1]).
  - P_blk=AND of all P_k.
  - G_blk=cout evaluated with cin=0.
- Implement the function as a parallel prefix (log2 levels), split across two register stages:
  - S1 registers the inputs plus the first ceil(L/2) prefix levels.
  - S2 registers the remaining levels and the final carries.
  - Ripple evaluation is not allowed.
- Handshakes:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
- Latency:
  - An accepted transaction appears on outputs exactly 2 cycles after acceptance when not stalled.
  - Throughput is 1 per cycle.
- Ready logic:
  - S2 advances when !s2_valid | out_ready.
  - S1 advances when !s1_valid | (S2 advances).
  - in_ready = !s1_valid | (S2 advances). This is combinational from out_ready; there is no combinational path from in_valid.
- Stall: while out_valid & !out_ready, c_grp/cout/blk_qg/out_valid hold stable. No transaction is dropped or duplicated.
- Bubbles: an empty stage has valid=0. Its data registers may hold stale values; outputs are don't-care while out_valid=0.
- Simultaneous events (S2 full, out_ready=1, S1 full, in_valid=1): all three transfers occur in the same cycle.
- Reset:
  - rst=1 clears s1_valid and s2_valid.
  - Next cycle: out_valid=0, in_ready=1, c_grp=0, cout=0, blk_qg=0.
  - Reset mid-operation discards all in-flight transactions. No output is produced for them.
  - in_ready=0 while rst=1.
- X-safety: qg_in/cin are sampled only on an accepted transfer.
- Transaction ordering is strictly preserved.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 → no transfer; after release out_valid=0, in_ready=1, all outputs 0.
- All-propagate, NumGroups=4: qg_in=8'b01010101, cin=1 → 2 cycles later c_grp=4'b1111, cout=1, blk_qg=2'b01. Same input with cin=0 → c_grp=4'b0000, cout=0, blk_qg=2'b01.
- Isolated generate: qg_in=8'b00001000, cin=0 → c_grp=4'b0100, cout=0, blk_qg=2'b00.
- Generate-propagate chain: qg_in=8'b01010110, cin=0 → c_grp=4'b1110, cout=1, blk_qg=2'b10.
- Back-pressure and throughput:
  - Send 6 back-to-back random transactions with out_ready=1 → results arrive on 6 consecutive cycles starting at cycle 2, matching the ripple reference model.
  - Then hold out_ready=0 for 3 cycles mid-stream → in_ready drops after both stages fill, outputs stay stable, and no loss or duplication occurs once out_ready=1.
- Reset mid-flight: accept 2 transactions, assert rst on the next cycle → out_valid never rises for them; the first post-reset transaction returns after exactly 2 cycles with correct values.
